adder_result_fifo: RTL and testbench

ADDER_RESULT_FIFO -- requirements
Module: adder_result_fifo

---
 rtl/adder_result_fifo.sv | 110 +++++++++++
 tb/tb_adder_result_fifo.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : adder_result_fifo
// Description : Credit-controlled result FIFO behind a fixed-latency adder.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_result_fifo #(
    parameter int LATENCY = 4,
    parameter int DEPTH   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       cout,
    input  logic [7:0] sum,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [8:0] out_data,
    output logic [3:0] count,
    output logic       err
);

    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0] c_DEPTH = 8'(DEPTH);

    logic [LATENCY-1:0] r_vpipe;
    logic [8:0]         r_mem [DEPTH];
    logic [AW-1:0]      r_wptr;
    logic [AW-1:0]      r_rptr;
    logic [3:0]         r_count;
    logic               r_err;

    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic [7:0]         w_inflight;
    logic [7:0]         w_credit;

    // Results already in the adder pipeline hold a reserved FIFO slot.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            w_inflight = w_inflight + 8'(r_vpipe[i]);
        end
    end

    assign w_credit  = w_inflight + {4'd0, r_count};
    assign in_ready  = (w_credit < c_DEPTH);
    assign w_accept  = in_valid & in_ready;
    assign w_push    = r_vpipe[LATENCY-1];
    assign out_valid = (r_count != 4'd0);
    assign w_pop     = out_valid & out_ready;
    assign out_data  = r_mem[r_rptr];
    assign count     = r_count;
    assign err       = r_err;

    generate
        if (LATENCY == 1) begin : g_vpipe_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vpipe <= '0;
                end else begin
                    r_vpipe <= w_accept;
                end
            end
        end else begin : g_vpipe_multi
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vpipe <= '0;
                end else begin
                    r_vpipe <= {r_vpipe[LATENCY-2:0], w_accept};
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {cout, sum};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase
            // A refused operand set is not tracked; the flag stays until reset.
            if (in_valid && !in_ready) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adder_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_result_fifo
// Description : Randomized scoreboard bench for adder_result_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_result_fifo;

    localparam int LATENCY = 4;
    localparam int DEPTH   = 8;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b1;
    logic       in_valid  = 1'b0;
    logic       in_ready;
    logic       cout;
    logic [7:0] sum;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [8:0] out_data;
    logic [3:0] count;
    logic       err;

    logic [7:0] ain = 8'd0;
    logic [7:0] bin = 8'd0;
    logic       cin = 1'b0;

    always #5 clk = ~clk;

    adder_result_fifo #(
        .LATENCY (LATENCY),
        .DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cout      (cout),
        .sum       (sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .err       (err)
    );

    // External adder: registers operands every edge, result emerges LATENCY-1 edges later.
    logic [8:0] add_pipe [LATENCY];
    always @(posedge clk) begin
        for (int i = LATENCY - 1; i > 0; i--) add_pipe[i] <= add_pipe[i-1];
        add_pipe[0] <= {1'b0, ain} + {1'b0, bin} + {8'd0, cin};
    end
    assign {cout, sum} = add_pipe[LATENCY-1];

    typedef struct {
        logic [8:0] data;
        int         acc_edge;
    } entry_t;

    entry_t exp_q[$];
    int     cyc       = 0;
    int     checks    = 0;
    int     errors    = 0;
    int     err_edge  = -1;
    int     accepts   = 0;
    int     max_count = 0;
    bit     last_acc  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: derive visible/outstanding results from accept history and compare.
    always @(negedge clk) begin : mon
        int n_out;
        int n_vis;
        if (!rst_n) begin
            check("reset_count", int'(count), 0);
            check("reset_out_valid", int'(out_valid), 0);
            check("reset_err", int'(err), 0);
        end else begin
            n_out = 0;
            n_vis = 0;
            foreach (exp_q[i]) begin
                if (exp_q[i].acc_edge <= cyc) n_out++;
                if (exp_q[i].acc_edge + LATENCY <= cyc) n_vis++;
            end
            check("in_ready", int'(in_ready), int'(n_out < DEPTH));
            check("out_valid", int'(out_valid), int'(n_vis > 0));
            check("count", int'(count), n_vis);
            check("err", int'(err), int'(err_edge >= 0 && cyc >= err_edge));
            if (n_vis > 0 && out_ready) begin
                check("out_data", int'(out_data), int'(exp_q[0].data));
                void'(exp_q.pop_front());
            end
        end
    end

    // One cycle of stimulus; gated=1 makes upstream honour in_ready.
    task automatic drive(input bit v, input bit gated, input logic [7:0] a,
                         input logic [7:0] b, input logic c, input bit ordy);
        entry_t e;
        ain       = a;
        bin       = b;
        cin       = c;
        out_ready = ordy;
        in_valid  = gated ? (v && in_ready) : v;
        last_acc  = in_valid && in_ready;
        if (last_acc) begin
            e.data     = {1'b0, a} + {1'b0, b} + {8'd0, c};
            e.acc_edge = cyc + 1;
            exp_q.push_back(e);
            accepts++;
        end else if (in_valid && err_edge < 0) begin
            err_edge = cyc + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            drive(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
            n++;
        end
        check("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic do_reset(input int cycles);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        err_edge  = -1;
        repeat (cycles) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2;
        do_reset(2);

        // Single operation: 200 + 100 + 1 = 301
        drive(1'b1, 1'b0, 8'd200, 8'd100, 1'b1, 1'b0);
        repeat (3) drive(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        check("single_no_early", int'(out_valid), 0);
        drive(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        check("single_valid", int'(out_valid), 1);
        check("single_data", int'(out_data), 9'h12D);
        check("single_count", int'(count), 1);
        drive(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
        check("single_pop_count", int'(count), 0);

        // Fill under credit with no draining
        accepts = 0;
        repeat (14) drive(1'b1, 1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
        check("fill_accepts", accepts, DEPTH);
        check("fill_count", int'(count), DEPTH);
        check("fill_in_ready", int'(in_ready), 0);
        check("fill_err", int'(err), 0);
        drain();

        // Streaming: ungated, so any in_ready drop would raise err
        max_count = 0;
        repeat (200) begin
            drive(1'b1, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
            if (int'(count) > max_count) max_count = int'(count);
        end
        check("stream_count_le1", int'(max_count <= 1), 1);
        check("stream_err", int'(err), 0);
        drain();

        // Ordered data 0..15 exercises pointer wrap
        begin
            int i = 0;
            int guard = 0;
            while (i < 16 && guard < 300) begin
                drive(1'b1, 1'b1, 8'(i), 8'd0, 1'b0, 1'($urandom_range(0, 2) == 0));
                if (last_acc) i++;
                guard++;
            end
            check("ordered_accepts", i, 16);
        end
        drain();

        // Random mix of valid and ready
        repeat (400) drive(1'($urandom), 1'b1, 8'($urandom), 8'($urandom),
                           1'($urandom), 1'($urandom_range(0, 2) == 0));
        drain();

        // Protocol violation and sticky err
        repeat (12) drive(1'b1, 1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
        check("viol_ready_low", int'(in_ready), 0);
        check("viol_err_before", int'(err), 0);
        drive(1'b1, 1'b0, 8'd1, 8'd2, 1'b0, 1'b0);
        check("viol_err_set", int'(err), 1);
        drain();
        check("viol_ready_back", int'(in_ready), 1);
        check("viol_err_sticky", int'(err), 1);
        do_reset(2);
        check("viol_err_cleared", int'(err), 0);

        // Reset with results in flight
        repeat (3) drive(1'b1, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
        do_reset(2);
        repeat (10) drive(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
        check("rst_flight_count", int'(count), 0);
        check("rst_flight_valid", int'(out_valid), 0);
        drive(1'b1, 1'b0, 8'd255, 8'd255, 1'b1, 1'b0);
        check("resume_accept", int'(last_acc), 1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
